apu_envelope: RTL

APU_ENVELOPE -- requirements
Module: apu_envelope

---
 rtl/apu_pkg.sv | 28 ++
 rtl/apu_qframe_div.sv | 31 +++
 rtl/apu_envelope.sv | 117 +++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared definitions for the APU pulse-channel envelope: config field layout,
// quarter-frame divider default, and a helper to split the raw config word.
package apu_pkg;

    localparam int QF_DIV_DEFAULT = 7457;
    localparam int QF_CNT_W       = 16;

    localparam int CFG_W          = 6;
    localparam int CFG_LOOP_BIT   = 5;
    localparam int CFG_CONST_BIT  = 4;
    localparam int CFG_VOL_MSB    = 3;
    localparam int CFG_VOL_LSB    = 0;

    typedef struct packed {
        logic       loop;
        logic       const_vol;
        logic [3:0] vol;
    } env_cfg_t;

    function automatic env_cfg_t unpack_cfg(input logic [CFG_W-1:0] raw);
        env_cfg_t c;
        c.loop      = raw[CFG_LOOP_BIT];
        c.const_vol = raw[CFG_CONST_BIT];
        c.vol       = raw[CFG_VOL_MSB:CFG_VOL_LSB];
        return c;
    endfunction

endpackage

// File: rtl/apu_qframe_div.sv
// Quarter-frame divider: counts accepted pulse samples and flags the one
// sample that completes each group of QF_DIV.
module apu_qframe_div
    import apu_pkg::*;
#(
    parameter int QF_DIV = QF_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    output logic tick
);

    localparam logic [QF_CNT_W-1:0] LAST = QF_CNT_W'(QF_DIV - 1);

    logic [QF_CNT_W-1:0] qf_cnt_reg;
    logic                at_last;

    assign at_last = (qf_cnt_reg == LAST);
    // Tick is combinational so it belongs to the very transaction that wraps.
    assign tick    = step & at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            qf_cnt_reg <= '0;
        end else if (step) begin
            qf_cnt_reg <= at_last ? '0 : qf_cnt_reg + QF_CNT_W'(1);
        end
    end

endmodule

// File: rtl/apu_envelope.sv
// Pulse-channel volume envelope: gates the incoming pulse bit with either a
// constant volume or a decaying level, through a single registered output stage.
module apu_envelope
    import apu_pkg::*;
#(
    parameter int QF_DIV = QF_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             apu__pulse_r,
    input  logic             apu__pulse_r_vld,
    output logic             apu__pulse_r_rdy,
    input  logic [CFG_W-1:0] apu__config_r,
    input  logic             apu__config_r_vld,
    output logic             apu__config_r_rdy,
    output logic [3:0]       apu__sample_s,
    output logic             apu__sample_s_vld,
    input  logic             apu__sample_s_rdy
);

    logic       sample_vld_reg;
    logic [3:0] sample_reg;
    logic [3:0] decay_reg;
    logic [3:0] divider_reg;
    logic       start_flag_reg;
    logic       loop_reg;
    logic       const_vol_reg;
    logic [3:0] vol_reg;

    logic [3:0] decay_next;
    logic [3:0] divider_next;
    logic       start_flag_next;
    logic [3:0] sample_next;

    logic       load_en;
    logic       pulse_txn;
    logic       cfg_acc;
    logic       qf_tick;
    env_cfg_t   cfg_in;

    assign load_en           = ~sample_vld_reg | apu__sample_s_rdy;
    assign pulse_txn         = apu__pulse_r_vld & load_en & ~reset;
    assign cfg_acc           = apu__config_r_vld & ~reset;
    assign cfg_in            = unpack_cfg(apu__config_r);

    assign apu__pulse_r_rdy  = pulse_txn;
    assign apu__config_r_rdy = ~reset;
    assign apu__sample_s     = sample_reg;
    assign apu__sample_s_vld = sample_vld_reg;

    apu_qframe_div #(
        .QF_DIV (QF_DIV)
    ) u_qframe_div (
        .clk   (clk),
        .reset (reset),
        .step  (pulse_txn),
        .tick  (qf_tick)
    );

    // The sample is formed from the state before any tick or config this cycle.
    assign sample_next = apu__pulse_r ? (const_vol_reg ? vol_reg : decay_reg) : 4'h0;

    always_comb begin
        decay_next      = decay_reg;
        divider_next    = divider_reg;
        start_flag_next = start_flag_reg;
        if (qf_tick) begin
            if (start_flag_reg) begin
                start_flag_next = 1'b0;
                decay_next      = 4'd15;
                divider_next    = vol_reg;
            end else if (divider_reg == 4'd0) begin
                divider_next = vol_reg;
                if (decay_reg != 4'd0) begin
                    decay_next = decay_reg - 4'd1;
                end else if (loop_reg) begin
                    decay_next = 4'd15;
                end
            end else begin
                divider_next = divider_reg - 4'd1;
            end
        end
        // A config landing on a tick restarts after the tick has used the old state.
        if (cfg_acc) begin
            start_flag_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_reg     <= 4'h0;
            sample_vld_reg <= 1'b0;
            decay_reg      <= 4'h0;
            divider_reg    <= 4'h0;
            start_flag_reg <= 1'b0;
            loop_reg       <= 1'b0;
            const_vol_reg  <= 1'b0;
            vol_reg        <= 4'h0;
        end else begin
            if (load_en) begin
                sample_vld_reg <= pulse_txn;
                if (pulse_txn) begin
                    sample_reg <= sample_next;
                end
            end
            decay_reg      <= decay_next;
            divider_reg    <= divider_next;
            start_flag_reg <= start_flag_next;
            if (cfg_acc) begin
                loop_reg      <= cfg_in.loop;
                const_vol_reg <= cfg_in.const_vol;
                vol_reg       <= cfg_in.vol;
            end
        end
    end

endmodule
